// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and default sizing.
package irq_pkg;

  localparam int NUM_IRQ_DEF = 24;
  localparam int VEC_W_DEF   = 5;

  localparam logic [2:0] REG_MASK_LO = 3'd0;
  localparam logic [2:0] REG_MASK_HI = 3'd1;
  localparam logic [2:0] REG_EDGE_LO = 3'd2;
  localparam logic [2:0] REG_EDGE_HI = 3'd3;
  localparam logic [2:0] REG_PEND_LO = 3'd4;
  localparam logic [2:0] REG_PEND_HI = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational priority encoder: the lowest set bit wins, index 0 is the
// highest priority.
module irq_priority_encoder #(
  parameter int N = 24,
  parameter int W = 5
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [W-1:0] index_o
);

  always_comb begin
    valid_o = |req_i;
    index_o = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) index_o = W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: synchronises the lines, keeps pending
// state, and runs the request/ack/service/done handshake towards the core.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int VEC_W   = VEC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [2:0]         reg_addr,
  input  logic               reg_wr,
  input  logic [11:0]        reg_wdata,
  output logic [11:0]        reg_rdata,
  output logic               int_req,
  input  logic               int_ack,
  output logic [VEC_W-1:0]   int_vector,
  input  logic               int_done,
  output logic               in_service,
  output irq_state_e         dbg_state
);

  // Handshake: int_req is held until int_ack (one-cycle pulse) is seen in
  // REQ; in_service is held from the accepting edge until the int_done pulse.

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, sprev_q;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] rise, clr, ack_clr, eligible;

  logic [23:0] mask_w, edge_w, pend_w;
  logic [23:0] mask_nx, edge_nx, w1c_w;
  logic [11:0] status_w;

  irq_state_e         state_q;
  logic               req_q, svc_q;
  logic [VEC_W-1:0]   vec_q;
  logic               win_valid;
  logic [VEC_W-1:0]   win_idx;
  logic               accept;

  // Register view padded to 24 bits; lines at or above NUM_IRQ read 0.
  always_comb begin
    mask_w = '0;
    edge_w = '0;
    pend_w = '0;
    mask_w[NUM_IRQ-1:0] = mask_q;
    edge_w[NUM_IRQ-1:0] = edge_q;
    pend_w[NUM_IRQ-1:0] = pend_q;
  end

  always_comb begin
    mask_nx = mask_w;
    edge_nx = edge_w;
    w1c_w   = '0;
    if (reg_wr) begin
      case (reg_addr)
        REG_MASK_LO: mask_nx[11:0]  = reg_wdata;
        REG_MASK_HI: mask_nx[23:12] = reg_wdata;
        REG_EDGE_LO: edge_nx[11:0]  = reg_wdata;
        REG_EDGE_HI: edge_nx[23:12] = reg_wdata;
        REG_PEND_LO: w1c_w[11:0]    = reg_wdata;
        REG_PEND_HI: w1c_w[23:12]   = reg_wdata;
        default: ;
      endcase
    end
    mask_d = mask_nx[NUM_IRQ-1:0];
    edge_d = edge_nx[NUM_IRQ-1:0];
  end

  irq_priority_encoder #(
    .N (NUM_IRQ),
    .W (VEC_W)
  ) u_prio (
    .req_i   (eligible),
    .valid_o (win_valid),
    .index_o (win_idx)
  );

  assign eligible = pend_q & mask_q;
  assign accept   = (state_q == REQ) && int_ack && win_valid;
  assign rise     = sync2_q & ~sprev_q;
  assign ack_clr  = accept ? (NUM_IRQ'(1) << win_idx) : '0;
  assign clr      = w1c_w[NUM_IRQ-1:0] | ack_clr;

  // Edge lines: a rising edge beats a same-cycle clear. Level lines mirror s.
  assign pend_d = (edge_q & (rise | (pend_q & ~clr))) | (~edge_q & sync2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sprev_q <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      sprev_q <= sync2_q;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      svc_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // A withdrawn request takes precedence over a late ack.
          if (!win_valid) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end else if (int_ack) begin
            vec_q   <= win_idx;
            req_q   <= 1'b0;
            svc_q   <= 1'b1;
            state_q <= SERVICE;
          end
        end
        SERVICE: begin
          if (int_done) begin
            svc_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          svc_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign int_req    = req_q;
  assign in_service = svc_q;
  assign int_vector = vec_q;
  assign dbg_state  = state_q;

  always_comb begin
    status_w      = '0;
    status_w[0]   = req_q;
    status_w[1]   = svc_q;
    status_w[6:2] = 5'(vec_q);
  end

  always_comb begin
    case (reg_addr)
      REG_MASK_LO: reg_rdata = mask_w[11:0];
      REG_MASK_HI: reg_rdata = mask_w[23:12];
      REG_EDGE_LO: reg_rdata = edge_w[11:0];
      REG_EDGE_HI: reg_rdata = edge_w[23:12];
      REG_PEND_LO: reg_rdata = pend_w[11:0];
      REG_PEND_HI: reg_rdata = pend_w[23:12];
      REG_STATUS:  reg_rdata = status_w;
      default:     reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: vector table for priority/mask
// patterns plus hand-written sequences for latency, collisions and reset.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int N  = 24;
  localparam int VW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic [2:0]    reg_addr;
  logic          reg_wr;
  logic [11:0]   reg_wdata;
  logic [11:0]   reg_rdata;
  logic          int_req;
  logic          int_ack;
  logic [VW-1:0] int_vector;
  logic          int_done;
  logic          in_service;
  irq_state_e    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_v;
  logic          svc_prev = 1'b0;

  irq_controller #(.NUM_IRQ(N), .VEC_W(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .reg_addr   (reg_addr),
    .reg_wr     (reg_wr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .int_req    (int_req),
    .int_ack    (int_ack),
    .int_vector (int_vector),
    .int_done   (int_done),
    .in_service (in_service),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted request must present the queued vector.
  always @(negedge clk) begin
    if (in_service && !svc_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_service actual=%0d required=none", int_vector);
      end else begin
        exp_v = exp_q.pop_front();
        check("vector", 32'(int_vector), 32'(exp_v));
      end
    end
    svc_prev = in_service;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [11:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    step(1);
    reg_wr    = 1'b0;
  endtask

  task automatic write24(input logic [2:0] lo, input logic [23:0] v);
    reg_write(lo, v[11:0]);
    reg_write(3'(lo + 3'd1), v[23:12]);
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic [11:0] exp);
    reg_addr = a;
    #1;
    check(name, 32'(reg_rdata), 32'(exp));
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step(1);
  endtask

  task automatic ack(input logic [VW-1:0] v);
    exp_q.push_back(v);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
  endtask

  task automatic done();
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
  endtask

  typedef struct {
    logic [23:0]   irq_v;
    logic [23:0]   mask;
    logic [23:0]   edge_m;
    logic          exp_req;
    logic [VW-1:0] exp_vec;
  } vec_t;

  vec_t vt[7];

  initial begin
    rst = 1'b1; irq = '0; reg_addr = '0; reg_wr = 1'b0; reg_wdata = '0;
    int_ack = 1'b0; int_done = 1'b0;

    vt[0] = '{24'hFFFFFF, 24'h000000, 24'h000000, 1'b0, 5'd0};
    vt[1] = '{24'h100008, 24'h100008, 24'h100008, 1'b1, 5'd3};
    vt[2] = '{24'h800000, 24'h800000, 24'h000000, 1'b1, 5'd23};
    vt[3] = '{24'h000F00, 24'h000C00, 24'h000000, 1'b1, 5'd10};
    vt[4] = '{24'h000001, 24'hFFFFFF, 24'h000000, 1'b1, 5'd0};
    vt[5] = '{24'h000020, 24'h000020, 24'h000000, 1'b1, 5'd5};
    vt[6] = '{24'h800100, 24'h800000, 24'h800100, 1'b1, 5'd23};

    // Reset with all lines high: everything reads 0 while reset is held.
    irq = '1;
    step(2);
    for (int a = 0; a < 7; a++) read_chk($sformatf("rst_reg%0d", a), 3'(a), 12'h000);
    check("rst_req", 32'(int_req), 0);
    check("rst_svc", 32'(in_service), 0);
    rst = 1'b0;
    step(5);
    check("nomask_req", 32'(int_req), 0);
    read_chk("level_pend_follows", REG_PEND_LO, 12'hFFF);
    irq = '0;

    // Edge line 12: one-clock pulse, request after E3.
    reset_pulse();
    write24(REG_MASK_LO, 24'h001000);
    write24(REG_EDGE_LO, 24'h001000);
    irq[12] = 1'b1;
    step(1);
    irq[12] = 1'b0;
    step(2);
    read_chk("e12_pend_e2", REG_PEND_HI, 12'h001);
    check("e12_req_e2", 32'(int_req), 0);
    step(1);
    check("e12_req_e3", 32'(int_req), 1);
    check("e12_state_req", 32'(dbg_state), 32'(REQ));
    ack(5'd12);
    check("e12_svc", 32'(in_service), 1);
    check("e12_req_off", 32'(int_req), 0);
    read_chk("e12_pend_cleared", REG_PEND_HI, 12'h000);
    read_chk("e12_status", REG_STATUS, 12'h032);
    done();
    check("e12_svc_off", 32'(in_service), 0);
    step(3);
    check("e12_no_rereq", 32'(int_req), 0);

    // Priority between edge lines 3 and 20.
    reset_pulse();
    write24(REG_MASK_LO, 24'h100008);
    write24(REG_EDGE_LO, 24'h100008);
    irq[3] = 1'b1; irq[20] = 1'b1;
    step(1);
    irq = '0;
    step(3);
    check("prio_req", 32'(int_req), 1);
    ack(5'd3);
    done();
    check("prio_gap", 32'(int_req), 0);
    step(1);
    check("prio_rereq", 32'(int_req), 1);
    ack(5'd20);
    read_chk("prio_pend_hi", REG_PEND_HI, 12'h000);
    done();

    // Level line 5 held through service, then W1C and release.
    reset_pulse();
    write24(REG_MASK_LO, 24'h000020);
    irq[5] = 1'b1;
    step(4);
    check("lvl_req", 32'(int_req), 1);
    ack(5'd5);
    read_chk("lvl_pend_after_ack", REG_PEND_LO, 12'h020);
    done();
    step(1);
    check("lvl_rereq", 32'(int_req), 1);
    reg_write(REG_PEND_LO, 12'h020);
    read_chk("lvl_w1c_ignored", REG_PEND_LO, 12'h020);
    irq[5] = 1'b0;
    step(2);
    read_chk("lvl_pend_e1", REG_PEND_LO, 12'h020);
    step(1);
    read_chk("lvl_pend_e2", REG_PEND_LO, 12'h000);
    check("lvl_req_hold", 32'(int_req), 1);
    step(1);
    check("lvl_req_drop", 32'(int_req), 0);

    // W1C colliding with a new edge on line 7: set wins.
    reset_pulse();
    write24(REG_EDGE_LO, 24'h000080);
    irq[7] = 1'b1;
    step(2);
    reg_write(REG_PEND_LO, 12'h080);
    read_chk("coll_set_wins", REG_PEND_LO, 12'h080);
    reg_write(REG_PEND_LO, 12'h080);
    read_chk("w1c_clears", REG_PEND_LO, 12'h000);

    // Mask cleared while requesting withdraws the request.
    irq[7] = 1'b0;
    step(3);
    irq[7] = 1'b1;
    step(3);
    read_chk("m_pend", REG_PEND_LO, 12'h080);
    reg_write(REG_MASK_LO, 12'h080);
    step(1);
    check("m_req_on", 32'(int_req), 1);
    reg_write(REG_MASK_LO, 12'h000);
    check("m_req_hold", 32'(int_req), 1);
    step(1);
    check("m_req_drop", 32'(int_req), 0);
    check("m_state_idle", 32'(dbg_state), 32'(IDLE));

    // Ignored handshake inputs.
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    check("ack_idle_svc", 32'(in_service), 0);
    read_chk("ack_idle_pend", REG_PEND_LO, 12'h080);
    reg_write(REG_MASK_LO, 12'h080);
    step(1);
    done();
    check("done_req_req", 32'(int_req), 1);
    check("done_req_svc", 32'(in_service), 0);
    exp_q.push_back(5'd7);
    int_ack = 1'b1; int_done = 1'b1;
    step(1);
    int_ack = 1'b0; int_done = 1'b0;
    check("ackdone_svc", 32'(in_service), 1);
    check("ackdone_req", 32'(int_req), 0);

    // New event latches during service; reset abandons the service.
    irq[7] = 1'b0;
    step(3);
    irq[7] = 1'b1;
    step(3);
    read_chk("svc_latch_pend", REG_PEND_LO, 12'h080);
    check("svc_no_req", 32'(int_req), 0);
    rst = 1'b1;
    #1;
    check("arst_svc", 32'(in_service), 0);
    read_chk("arst_pend", REG_PEND_LO, 12'h000);
    rst = 1'b0;
    irq = '0;
    step(1);
    done();
    check("post_rst_done_svc", 32'(in_service), 0);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));

    // Table of priority/mask patterns.
    for (int k = 0; k < 7; k++) begin
      irq = '0;
      reset_pulse();
      write24(REG_MASK_LO, vt[k].mask);
      write24(REG_EDGE_LO, vt[k].edge_m);
      irq = vt[k].irq_v;
      step(4);
      check($sformatf("tbl%0d_req", k), 32'(int_req), 32'(vt[k].exp_req));
      if (vt[k].exp_req) begin
        ack(vt[k].exp_vec);
        check($sformatf("tbl%0d_svc", k), 32'(in_service), 1);
        done();
        check($sformatf("tbl%0d_svc_off", k), 32'(in_service), 0);
      end
    end
    irq = '0;
    step(2);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt controller that sits between the 24 external interrupt lines and the Processor12 core.
- Synchronises the lines, latches pending events, and applies the mask and the edge/level configuration.
- Presents one request with a 5-bit vector to the core, and sequences the ack/service/done handshake.
- Configured by the core through a small 12-bit register port, matching the core's 12-bit data word.

Parameters:
- NUM_IRQ, 24, number of interrupt lines (1..24); unused upper register bits read 0.
- VEC_W, 5, vector width; must satisfy 2^VEC_W >= NUM_IRQ.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- irq  in  NUM_IRQ  raw interrupt lines, asynchronous to clk
- reg_addr  in  3  register select
- reg_wr  in  1  write strobe, one cycle
- reg_wdata  in  12  write data
- reg_rdata  out  12  read data, combinational from reg_addr
- int_req  out  1  interrupt request to core, registered
- int_ack  in  1  core accepts request, one-cycle pulse
- int_vector  out  VEC_W  id of the accepted line, held through service
- int_done  in  1  end-of-interrupt pulse from core
- in_service  out  1  high from ack to done

Behaviour:
- Reset (asynchronous, rst=1) clears all state:
  - int_req=0, int_vector=0, in_service=0, reg_rdata reflects cleared registers.
  - MASK=0 (all lines disabled), EDGE=0 (all lines level), PEND=0, synchroniser flops=0.
  - FSM enters IDLE.
  - Reset mid-service abandons the service; no done is required afterwards.
- Synchronisation:
  - Two-flop synchroniser per line, giving level s[i].
  - Rising edge of line i is s[i]=1 with its previous value 0.
- Pending bit, edge mode (EDGE[i]=1):
  - Set on a rising edge.
  - Cleared on ack of line i, or by writing 1 to its PEND bit.
  - If set and clear occur in the same cycle, set wins.
- Pending bit, level mode (EDGE[i]=0):
  - PEND[i] follows s[i]; write-1-to-clear has no effect.
  - Ack does not clear it; the source must deassert before the handler issues done.
- Eligible set = PEND & MASK. Winner = lowest-index eligible bit; index 0 has highest priority.
- FSM states and transitions:
  - IDLE: int_req is driven, on the next edge, to (eligible set nonzero). Go to REQ when int_req=1.
  - REQ, eligible set becomes empty (e.g. mask cleared): int_req drops on the next edge; return to IDLE.
  - REQ, int_ack=1: latch the winner's index into int_vector in that cycle; clear pending if the line is edge mode; int_req=0 and in_service=1 from the next edge; go to SERVICE.
  - SERVICE: no new request; further events still latch into PEND.
  - SERVICE, int_done=1: in_service=0 from the next edge; go to IDLE. A new request can appear one cycle later.
  - Interrupts do not nest.
- Ignored inputs:
  - int_ack outside REQ.
  - int_done outside SERVICE.
  - int_ack and int_done together: only the one valid for the current state acts.
- Latency:
  - Line i goes high before clock edge E0 (MASK[i]=1, IDLE).
  - s[i]=1 after E1; PEND[i]=1 after E2; int_req=1 after E3.
- Register map (the 24-bit registers are split into 12-bit halves):
  - 0 MASK[11:0], 1 MASK[23:12], both RW.
  - 2 EDGE[11:0], 3 EDGE[23:12], both RW.
  - 4 PEND[11:0], 5 PEND[23:12]: read returns current PEND; write is W1C, edge-mode bits only.
  - 6 STATUS, read-only: bit0=int_req, bit1=in_service, bits[6:2]=int_vector, other bits 0.
  - 7: reads 0; writes ignored.
- Writes take effect on the next edge. Bits at or above NUM_IRQ are not writable and read 0.

Decomposition:
- Shared package irq_pkg holds:
  - register address constants (REG_MASK_LO..REG_STATUS);
  - FSM state encoding (IDLE, REQ, SERVICE);
  - default NUM_IRQ and VEC_W.
- Sub-module irq_priority_encoder: combinational lowest-index-first encoder with outputs valid and index.
- Synchroniser, pending logic, registers and FSM live in irq_controller.

Test Plan:
- Reset behaviour: rst pulse with irq=all ones -> int_req=0, in_service=0, reads of registers 0..6 return 0; no request while MASK=0.
- Edge request and latency: MASK=0x000/0x001 (line 12 enabled), EDGE hi=0x001, pulse irq[12] for 1 clock at E0 -> int_req=1 after E3. Then:
  - ack -> int_vector=12, in_service=1, PEND hi reads 0;
  - done -> IDLE with no re-request.
- Priority: edge lines 3 and 20 pending with both enabled -> vector 3 first. After done, int_req reasserts one cycle later -> vector 20.
- Level mode: line 5 level-mode and enabled, held high through ack and done -> int_req reasserts after done. Then:
  - drop line 5 -> PEND[5]=0 three cycles later;
  - W1C write of 0x020 to register 4 -> no change to PEND.
- Collisions and ignored inputs:
  - W1C of line 7 in the same cycle as a new edge on line 7 -> PEND[7] stays 1.
  - Clear MASK during REQ -> int_req drops next cycle.
  - int_ack in IDLE, or int_done in REQ -> no state change.
- Reset mid-service: assert rst while in SERVICE -> in_service=0 and PEND=0 immediately (asynchronously); a later int_done is ignored.
